dmem_responder: RTL and testbench



---
 rtl/dmem_pkg.sv | 17 +
 rtl/dmem_responder_trace_fifo.sv | 60 ++++++
 rtl/dmem_responder.sv | 112 +++++++++++
 tb/tb_dmem_responder.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory responder and its trace FIFO.
package dmem_pkg;

   localparam int unsigned TOHOST_ADDR_DEFAULT = 100;
   localparam int unsigned PASS_VALUE_DEFAULT  = 25;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } trace_entry_t;

   typedef enum logic {
      RUN  = 1'b0,
      DONE = 1'b1
   } run_state_t;

endpackage

// File: rtl/dmem_responder_trace_fifo.sv
// trace_fifo: synchronous FIFO of store-trace entries with sticky overflow.
// Full is judged at the start of the cycle, so a pop never makes room for a same-cycle push.
module trace_fifo
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push_i,
   input  trace_entry_t push_data_i,
   input  logic         pop_i,
   output trace_entry_t head_o,
   output logic         empty_o,
   output logic         full_o,
   output logic         ovf_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   logic [PW-1:0] wr_q, wr_d;
   logic [PW-1:0] rd_q, rd_d;
   logic          ovf_q, ovf_d;
   logic          do_push, do_pop;
   trace_entry_t  mem_q [DEPTH];

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign empty_o = (wr_q == rd_q);
   assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign head_o  = mem_q[rd_q[AW-1:0]];
   assign ovf_o   = ovf_q;

   always_comb begin
      wr_d  = wr_q + PW'(do_push);
      rd_d  = rd_q + PW'(do_pop);
      ovf_d = ovf_q | (push_i & full_o);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_q  <= '0;
         rd_q  <= '0;
         ovf_q <= 1'b0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         ovf_q <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && do_push) begin
         mem_q[wr_q[AW-1:0]] <= push_data_i;
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: word RAM, tohost verdict register and store-trace FIFO for the MEM stage.
// Optional: define DMEM_MISALIGN_CHECK_EN to turn misaligned stores into a fail verdict.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 64,
   parameter int unsigned TOHOST_ADDR = TOHOST_ADDR_DEFAULT,
   parameter int unsigned PASS_VALUE  = PASS_VALUE_DEFAULT,
   parameter int unsigned TRACE_DEPTH = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemWrite,
   input  logic [31:0] DataAdr,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        done,
   output logic        pass,
   output logic        trace_valid,
   input  logic        trace_ready,
   output logic [31:0] trace_addr,
   output logic [31:0] trace_data,
   output logic        trace_ovf
);

   localparam int unsigned IW = $clog2(DEPTH_WORDS);

   run_state_t    state_q, state_d;
   logic          pass_q, pass_d;
   logic          ram_we;
   logic          is_tohost;
   logic          misalign;
   logic [IW-1:0] index;
   logic [31:0]   ram_q [DEPTH_WORDS];
   trace_entry_t  push_entry;
   trace_entry_t  head;
   logic          fifo_empty;
   logic          fifo_full_unused;

   assign index     = DataAdr[IW+1:2];
   assign is_tohost = (DataAdr == 32'(TOHOST_ADDR));

`ifdef DMEM_MISALIGN_CHECK_EN
   assign misalign = (DataAdr[1:0] != 2'b00);
`else
   assign misalign = 1'b0;
`endif

   assign ReadData = is_tohost ? {30'b0, pass_q, (state_q == DONE)} : ram_q[index];
   assign done     = (state_q == DONE);
   assign pass     = pass_q;

   // Verdict FSM: first tohost (or misaligned) store freezes done/pass.
   always_comb begin
      state_d = state_q;
      pass_d  = pass_q;
      ram_we  = 1'b0;
      if (MemWrite) begin
         if (is_tohost) begin
            if (state_q == RUN) begin
               state_d = DONE;
               pass_d  = (WriteData == 32'(PASS_VALUE));
            end
         end else if (misalign) begin
            if (state_q == RUN) begin
               state_d = DONE;
               pass_d  = 1'b0;
            end
         end else begin
            ram_we = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RUN;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pass_q  <= pass_d;
      end
   end

   // RAM is deliberately not cleared by reset.
   always_ff @(posedge clk) begin
      if (!reset && ram_we) begin
         ram_q[index] <= WriteData;
      end
   end

   assign push_entry = '{addr: DataAdr, data: WriteData};

   trace_fifo #(
      .DEPTH (TRACE_DEPTH)
   ) u_trace_fifo (
      .clk         (clk),
      .reset       (reset),
      .push_i      (MemWrite && !reset),
      .push_data_i (push_entry),
      .pop_i       (trace_ready),
      .head_o      (head),
      .empty_o     (fifo_empty),
      .full_o      (fifo_full_unused),
      .ovf_o       (trace_ovf)
   );

   assign trace_valid = !fifo_empty;
   assign trace_addr  = head.addr;
   assign trace_data  = head.data;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed testbench for dmem_responder: verdict register, RAM, and trace FIFO behaviour.
module tb_dmem_responder;

   logic        clk;
   logic        reset;
   logic        MemWrite;
   logic [31:0] DataAdr;
   logic [31:0] WriteData;
   logic [31:0] ReadData;
   logic        done;
   logic        pass;
   logic        trace_valid;
   logic        trace_ready;
   logic [31:0] trace_addr;
   logic [31:0] trace_data;
   logic        trace_ovf;

   int checks = 0;
   int errors = 0;

   dmem_responder dut (
      .clk         (clk),
      .reset       (reset),
      .MemWrite    (MemWrite),
      .DataAdr     (DataAdr),
      .WriteData   (WriteData),
      .ReadData    (ReadData),
      .done        (done),
      .pass        (pass),
      .trace_valid (trace_valid),
      .trace_ready (trace_ready),
      .trace_addr  (trace_addr),
      .trace_data  (trace_data),
      .trace_ovf   (trace_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1ns after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_store(input logic [31:0] a, input logic [31:0] d);
      DataAdr   = a;
      WriteData = d;
      MemWrite  = 1'b1;
      tick();
      MemWrite  = 1'b0;
   endtask

   task automatic do_reset();
      reset       = 1'b1;
      MemWrite    = 1'b0;
      trace_ready = 1'b0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      DataAdr = 32'd0;
      #1;
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
      checks++; if (pass !== 1'b0) begin errors++; $display("FAIL reset_pass got %b exp 0", pass); end
      checks++; if (trace_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", trace_valid); end
      checks++; if (trace_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", trace_ovf); end
      DataAdr = 32'd100;
      #1;
      checks++; if (ReadData !== 32'd0) begin errors++; $display("FAIL reset_tohost_read got %h exp 0", ReadData); end
   endtask

   task automatic test_store_load();
      do_reset();
      DataAdr = 32'd96; WriteData = 32'd7; MemWrite = 1'b1;
      #1;
      checks++; if (trace_valid !== 1'b0) begin errors++; $display("FAIL no_bypass got %b exp 0", trace_valid); end
      tick();
      MemWrite = 1'b0;
      #1;
      checks++; if (ReadData !== 32'd7) begin errors++; $display("FAIL load96 got %h exp 7", ReadData); end
      checks++; if (trace_valid !== 1'b1) begin errors++; $display("FAIL trace_valid got %b exp 1", trace_valid); end
      checks++; if (trace_addr !== 32'd96 || trace_data !== 32'd7) begin errors++;
         $display("FAIL trace_head got %0d/%0d exp 96/7", trace_addr, trace_data); end
      // Same-cycle load of the stored address sees the old word.
      DataAdr = 32'd96; WriteData = 32'd8; MemWrite = 1'b1;
      #1;
      checks++; if (ReadData !== 32'd7) begin errors++; $display("FAIL read_during_write got %h exp 7", ReadData); end
      tick();
      MemWrite = 1'b0;
      #1;
      checks++; if (ReadData !== 32'd8) begin errors++; $display("FAIL load96_new got %h exp 8", ReadData); end
      // Alias: address 96+256 maps to the same word.
      DataAdr = 32'd352;
      #1;
      checks++; if (ReadData !== 32'd8) begin errors++; $display("FAIL alias352 got %h exp 8", ReadData); end
   endtask

   task automatic test_tohost_pass();
      do_reset();
      do_store(32'd356, 32'hAA);
      do_store(32'd100, 32'd25);
      checks++; if (done !== 1'b1 || pass !== 1'b1) begin errors++;
         $display("FAIL pass_verdict got done=%b pass=%b exp 1/1", done, pass); end
      DataAdr = 32'd356;
      #1;
      checks++; if (ReadData !== 32'hAA) begin errors++; $display("FAIL word25_kept got %h exp aa", ReadData); end
      DataAdr = 32'd100;
      #1;
      checks++; if (ReadData !== 32'd3) begin errors++; $display("FAIL tohost_read got %h exp 3", ReadData); end
      do_store(32'd100, 32'd3);
      checks++; if (done !== 1'b1 || pass !== 1'b1) begin errors++;
         $display("FAIL first_verdict_wins got done=%b pass=%b exp 1/1", done, pass); end
      checks++; if (trace_addr !== 32'd356 || trace_data !== 32'hAA) begin errors++;
         $display("FAIL tohost_trace_head got %0d/%h exp 356/aa", trace_addr, trace_data); end
   endtask

   task automatic test_tohost_fail();
      do_reset();
      do_store(32'd100, 32'd4);
      checks++; if (done !== 1'b1 || pass !== 1'b0) begin errors++;
         $display("FAIL fail_verdict got done=%b pass=%b exp 1/0", done, pass); end
      do_store(32'd100, 32'd25);
      checks++; if (pass !== 1'b0) begin errors++; $display("FAIL fail_frozen got %b exp 0", pass); end
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 0; i < 9; i++) do_store(32'(4 * i), 32'(32'h100 + i));
      checks++; if (trace_valid !== 1'b1 || trace_ovf !== 1'b1) begin errors++;
         $display("FAIL ovf_flags got valid=%b ovf=%b exp 1/1", trace_valid, trace_ovf); end
      trace_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (trace_valid !== 1'b1 || trace_addr !== 32'(4 * i) || trace_data !== 32'(32'h100 + i)) begin
            errors++;
            $display("FAIL drain%0d got v=%b %0d/%h exp 1 %0d/%h", i, trace_valid, trace_addr, trace_data,
                     4 * i, 32'h100 + i);
         end
         tick();
      end
      trace_ready = 1'b0;
      checks++; if (trace_valid !== 1'b0) begin errors++; $display("FAIL drained_empty got %b exp 0", trace_valid); end
      checks++; if (trace_ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", trace_ovf); end
   endtask

   task automatic test_full_pop();
      do_reset();
      for (int i = 0; i < 8; i++) do_store(32'(4 * i), 32'(i));
      checks++; if (trace_ovf !== 1'b0) begin errors++; $display("FAIL full_no_ovf got %b exp 0", trace_ovf); end
      // Push while full with a pop: the pop happens, the push is still dropped.
      trace_ready = 1'b1;
      do_store(32'd200, 32'hEE);
      checks++; if (trace_ovf !== 1'b1) begin errors++; $display("FAIL full_pop_ovf got %b exp 1", trace_ovf); end
      for (int i = 1; i < 8; i++) begin
         checks++;
         if (trace_valid !== 1'b1 || trace_addr !== 32'(4 * i)) begin
            errors++;
            $display("FAIL fullpop_drain%0d got v=%b %0d exp 1 %0d", i, trace_valid, trace_addr, 4 * i);
         end
         tick();
      end
      trace_ready = 1'b0;
      checks++; if (trace_valid !== 1'b0) begin errors++; $display("FAIL fullpop_empty got %b exp 0", trace_valid); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      do_store(32'd8, 32'h11);
      trace_ready = 1'b1;
      do_store(32'd12, 32'h22);
      checks++; if (trace_valid !== 1'b1 || trace_addr !== 32'd12 || trace_data !== 32'h22) begin errors++;
         $display("FAIL push_pop got v=%b %0d/%h exp 1 12/22", trace_valid, trace_addr, trace_data); end
      tick();
      trace_ready = 1'b0;
      checks++; if (trace_valid !== 1'b0) begin errors++; $display("FAIL push_pop_empty got %b exp 0", trace_valid); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      do_store(32'd100, 32'd4);
      for (int i = 0; i < 9; i++) do_store(32'd0, 32'(i));
      do_store(32'd40, 32'h33);
      // Reset together with a store: store discarded, all status cleared.
      reset = 1'b1; DataAdr = 32'd40; WriteData = 32'h44; MemWrite = 1'b1;
      tick();
      reset = 1'b0; MemWrite = 1'b0;
      #1;
      checks++; if (done !== 1'b0 || pass !== 1'b0) begin errors++;
         $display("FAIL midreset_verdict got done=%b pass=%b exp 0/0", done, pass); end
      checks++; if (trace_valid !== 1'b0 || trace_ovf !== 1'b0) begin errors++;
         $display("FAIL midreset_fifo got v=%b ovf=%b exp 0/0", trace_valid, trace_ovf); end
      checks++; if (ReadData !== 32'h33) begin errors++; $display("FAIL midreset_ram got %h exp 33", ReadData); end
   endtask

   task automatic test_misalign();
      do_reset();
      do_store(32'd96, 32'h11);
      do_store(32'd98, 32'd5);
      DataAdr = 32'd96;
      #1;
`ifdef DMEM_MISALIGN_CHECK_EN
      checks++; if (done !== 1'b1 || pass !== 1'b0) begin errors++;
         $display("FAIL misalign_verdict got done=%b pass=%b exp 1/0", done, pass); end
      checks++; if (ReadData !== 32'h11) begin errors++; $display("FAIL misalign_ram got %h exp 11", ReadData); end
`else
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL misalign_done got %b exp 0", done); end
      checks++; if (ReadData !== 32'd5) begin errors++; $display("FAIL misalign_ram got %h exp 5", ReadData); end
`endif
      trace_ready = 1'b1;
      tick();
      trace_ready = 1'b0;
      checks++; if (trace_valid !== 1'b1 || trace_addr !== 32'd98 || trace_data !== 32'd5) begin errors++;
         $display("FAIL misalign_trace got v=%b %0d/%0d exp 1 98/5", trace_valid, trace_addr, trace_data); end
   endtask

   initial begin
      reset       = 1'b1;
      MemWrite    = 1'b0;
      DataAdr     = '0;
      WriteData   = '0;
      trace_ready = 1'b0;
      test_reset();
      test_store_load();
      test_tohost_pass();
      test_tohost_fail();
      test_overflow();
      test_full_pop();
      test_back_to_back();
      test_reset_mid();
      test_misalign();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
